ones_stream_accumulator: RTL

- Streaming stage directly downstream of bitwise_ones_counter.
- Accepts a valid/ready stream of 4-bit nibbles grouped into frames by in_last. Each accepted nibble is passed through a bitwise_ones_counter instance and its 3-bit popcount is added into a running total.
- At frame end, presents the total set-bit count, the beat count and an overflow flag on a valid/ready output for the next stage.

---
 rtl/ones_stream_accumulator_pkg.sv | 27 ++
 rtl/ones_stream_accumulator_if.sv | 30 +++
 rtl/ones_stream_accumulator_popcount.sv | 14 +
 rtl/ones_stream_accumulator.sv | 105 ++++++++++
 4 files changed

// File: rtl/ones_stream_accumulator_pkg.sv
// Shared types, widths and saturating arithmetic for the ones-count stream stage.
// The popcount width and nibble width are fixed by the upstream counter.
package ones_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int unsigned PC_W     = 3;
  localparam int unsigned NIBBLE_W = 4;

  // Returns {clamped, sum}; the sum never exceeds 2^w-1, so no wrap-around can occur.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [31:0] maxv;
    maxv = (32'd1 << w) - 32'd1;
    s    = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, maxv}) begin
      return {1'b1, maxv};
    end
    return {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/ones_stream_accumulator_if.sv
// Nibble input stream and frame-result output stream of the ones accumulator.
// The master side feeds nibbles and consumes results; the slave side is the accumulator.
interface ones_stream_accumulator_if
  import ones_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned BEAT_W = 6
);

  logic                in_valid;
  logic                in_ready;
  logic [NIBBLE_W-1:0] in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [CNT_W-1:0]    out_count;
  logic [BEAT_W-1:0]   out_beats;
  logic                out_overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_beats, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count, out_beats, out_overflow
  );

endinterface

// File: rtl/ones_stream_accumulator_popcount.sv
// Combinational population count of a single nibble (0..4 set bits).
// Adds no latency to the accumulator datapath.
module bitwise_ones_counter
  import ones_pkg::*;
(
  input  logic [NIBBLE_W-1:0] In,
  output logic [PC_W-1:0]     out
);

  always_comb begin
    out = {2'b00, In[0]} + {2'b00, In[1]} + {2'b00, In[2]} + {2'b00, In[3]};
  end

endmodule

// File: rtl/ones_stream_accumulator.sv
// Accumulates per-nibble popcounts over a frame and hands the saturating totals,
// beat count and overflow flag to the next stage on a valid/ready output.
module ones_stream_accumulator
  import ones_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned BEAT_W = 6
)(
  input  logic                    clk,
  input  logic                    rst,
  ones_stream_accumulator_if.slave s
);

  state_t              state;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [CNT_W-1:0]    acc;
  logic [BEAT_W-1:0]   beat_acc;
  logic                ovf_acc;
  logic [CNT_W-1:0]    out_count_r;
  logic [BEAT_W-1:0]   out_beats_r;
  logic                out_overflow_r;

  logic [PC_W-1:0]     pc;
  logic [32:0]         cnt_sum;
  logic [32:0]         beat_sum;
  logic [CNT_W-1:0]    acc_nxt;
  logic [BEAT_W-1:0]   beat_nxt;
  logic                ovf_nxt;
  logic                accept;
  logic                unused_hi;

  bitwise_ones_counter u_pc (
    .In  (s.in_data),
    .out (pc)
  );

  // Next-beat totals, including the beat being offered this cycle.
  always_comb begin
    cnt_sum  = sat_add(32'(acc), 32'(pc), CNT_W);
    beat_sum = sat_add(32'(beat_acc), 32'd1, BEAT_W);
    acc_nxt  = cnt_sum[CNT_W-1:0];
    beat_nxt = beat_sum[BEAT_W-1:0];
    ovf_nxt  = ovf_acc | cnt_sum[32] | beat_sum[32];
    accept   = s.in_valid && in_ready_r;
  end

  assign unused_hi = ^{cnt_sum[31:CNT_W], beat_sum[31:BEAT_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ACCUM;
      in_ready_r     <= 1'b1;
      out_valid_r    <= 1'b0;
      acc            <= '0;
      beat_acc       <= '0;
      ovf_acc        <= 1'b0;
      out_count_r    <= '0;
      out_beats_r    <= '0;
      out_overflow_r <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (s.in_last) begin
              out_count_r    <= acc_nxt;
              out_beats_r    <= beat_nxt;
              out_overflow_r <= ovf_nxt;
              acc            <= '0;
              beat_acc       <= '0;
              ovf_acc        <= 1'b0;
              state          <= HOLD;
              in_ready_r     <= 1'b0;
              out_valid_r    <= 1'b1;
            end else begin
              acc      <= acc_nxt;
              beat_acc <= beat_nxt;
              ovf_acc  <= ovf_nxt;
            end
          end
        end
        HOLD: begin
          // Input stays blocked for the whole hold, giving the per-frame bubble.
          if (s.out_ready) begin
            state       <= ACCUM;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state       <= ACCUM;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign s.in_ready     = in_ready_r;
  assign s.out_valid    = out_valid_r;
  assign s.out_count    = out_count_r;
  assign s.out_beats    = out_beats_r;
  assign s.out_overflow = out_overflow_r;

endmodule
